// File: rtl/div_seq_32.sv
// div_seq_32: multicycle signed integer divider (restoring shift-and-subtract).
// One quotient bit per clock. Operands are latched as magnitudes and the
// signs are re-applied when the result is written. Quotient truncates
// toward zero and the remainder carries the dividend's sign.
module div_seq_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             result_valid,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int               CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_1 = CNT_W'(1);
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Working registers: partial remainder, dividend shifting into quotient,
  // divisor magnitude and the two result signs.
  logic [WIDTH-1:0] rem_p0;
  logic [WIDTH-1:0] quo_p0;
  logic [WIDTH-1:0] dvs_p0;
  logic             sign_q_p0;
  logic             sign_r_p0;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             load;

  // Two's complement magnitude. The most negative value maps to
  // 2^(WIDTH-1), which is still correct when read as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] u;
    u = v;
    return v[WIDTH-1] ? (~u + ONE) : u;
  endfunction

  // Re-apply a sign to an unsigned magnitude, wrapping modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] apply_sign(input logic neg,
                                                  input logic [WIDTH-1:0] mag);
    return neg ? (~mag + ONE) : mag;
  endfunction

  assign load   = (state != RUN) && start && (divisor != '0);
  assign rem_sh = {rem_p0, quo_p0[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs_p0};

  // Control FSM with registered outputs; result written on DONE entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      quotient     <= '0;
      remainder    <= '0;
      result_valid <= 1'b0;
      div_by_zero  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          result_valid <= 1'b0;
          state        <= IDLE;
          if (start) begin
            if (divisor == '0) begin
              state        <= DONE;
              quotient     <= '0;
              remainder    <= '0;
              div_by_zero  <= 1'b1;
              result_valid <= 1'b1;
              busy         <= 1'b0;
            end else begin
              state       <= RUN;
              cnt         <= '0;
              busy        <= 1'b1;
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          if (cnt == LAST) begin
            quotient     <= apply_sign(sign_q_p0, quo_p0);
            remainder    <= apply_sign(sign_r_p0, rem_p0);
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= DONE;
          end else begin
            cnt <= cnt + CNT_1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: load magnitudes on accept, then one restoring step per cycle.
  always_ff @(posedge clock) begin
    if (load) begin
      rem_p0    <= '0;
      quo_p0    <= magnitude($signed(dividend));
      dvs_p0    <= magnitude($signed(divisor));
      sign_q_p0 <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      sign_r_p0 <= dividend[WIDTH-1];
    end else if (state == RUN && cnt != LAST) begin
      // --- iteration boundary: shift, trial subtract, keep or restore ---
      if (!trial[WIDTH]) begin
        rem_p0 <= trial[WIDTH-1:0];
        quo_p0 <= {quo_p0[WIDTH-2:0], 1'b1};
      end else begin
        rem_p0 <= rem_sh[WIDTH-1:0];
        quo_p0 <= {quo_p0[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_div_seq_32.sv
// Testbench for div_seq_32: cycle-level reference model plus directed
// vectors with literal expected quotients, remainders and latencies.
module tb_div_seq_32;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;
  logic          result_valid;
  logic          div_by_zero;
  logic          busy;

  int checks = 0;
  int failures = 0;

  div_seq_32 #(.WIDTH(W)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .result_valid(result_valid),
    .div_by_zero(div_by_zero),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Reference model: arithmetic via 64-bit signed division, timing via
  // a countdown of the cycles a division occupies.
  logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  logic         m_valid = 1'b0, m_dbz = 1'b0, m_busy = 1'b0, m_pend = 1'b0;
  int           m_left = 0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_q = '0; m_r = '0; m_valid = 1'b0; m_dbz = 1'b0;
      m_busy = 1'b0; m_pend = 1'b0; m_left = 0;
    end else begin
      m_valid = 1'b0;
      if (m_pend) begin
        m_left--;
        if (m_left == 0) begin
          m_q = p_q; m_r = p_r; m_valid = 1'b1; m_busy = 1'b0; m_pend = 1'b0;
        end
      end else if (start) begin
        if (divisor == '0) begin
          m_q = '0; m_r = '0; m_dbz = 1'b1; m_valid = 1'b1;
        end else begin
          longint a, b, q64, r64;
          a = longint'($signed(dividend));
          b = longint'($signed(divisor));
          q64 = a / b;
          r64 = a - q64 * b;
          p_q = q64[W-1:0];
          p_r = r64[W-1:0];
          m_pend = 1'b1; m_left = W + 1; m_busy = 1'b1; m_dbz = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    chk("model result_valid", W'(result_valid), W'(m_valid));
    chk("model busy", W'(busy), W'(m_busy));
    chk("model div_by_zero", W'(div_by_zero), W'(m_dbz));
    chk("model quotient", quotient, m_q);
    chk("model remainder", remainder, m_r);
  end

  // Present one start pulse; returns at the falling edge after the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clock);
    start = 1'b0; dividend = $urandom; divisor = $urandom;
  endtask

  // Wait (bounded) for result_valid, optionally injecting a start pulse
  // 'inj' cycles after the accept edge, then check latency and values.
  task automatic wait_result(input string name, input logic [W-1:0] eq,
                             input logic [W-1:0] er, input logic edbz,
                             input int elat, input int inj);
    int n;
    for (n = 0; n <= 40; n++) begin
      if (result_valid) break;
      if (n == inj) begin
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    start = 1'b0;
    chk({name, " latency"}, W'(n), W'(elat));
    chk({name, " quotient"}, quotient, eq);
    chk({name, " remainder"}, remainder, er);
    chk({name, " div_by_zero"}, W'(div_by_zero), W'(edbz));
    chk({name, " busy at valid"}, W'(busy), '0);
  endtask

  initial begin
    int cnt;
    int gap;
    repeat (2) @(negedge clock);
    chk("reset quotient", quotient, '0);
    chk("reset valid", W'(result_valid), '0);
    chk("reset busy", W'(busy), '0);
    reset_n = 1'b1;

    // Basic case with latency and busy timing.
    issue(32'd100, 32'd7);
    chk("100/7 busy after accept", W'(busy), W'(1));
    wait_result("100/7", 32'd14, 32'd2, 1'b0, 33, -1);
    @(negedge clock);
    chk("100/7 valid one cycle", W'(result_valid), '0);

    // Sign combinations.
    issue(-32'sd100, 32'd7);
    wait_result("-100/7", -32'sd14, -32'sd2, 1'b0, 33, -1);
    issue(32'd100, -32'sd7);
    wait_result("100/-7", -32'sd14, 32'd2, 1'b0, 33, -1);
    issue(-32'sd100, -32'sd7);
    wait_result("-100/-7", 32'd14, -32'sd2, 1'b0, 33, -1);
    issue(32'd0, 32'd5);
    wait_result("0/5", 32'd0, 32'd0, 1'b0, 33, -1);

    // Divide by zero, then a normal division clears the flag.
    issue(32'd1234, 32'd0);
    wait_result("1234/0", 32'd0, 32'd0, 1'b1, 0, -1);
    issue(32'd9, 32'd3);
    chk("9/3 dbz cleared on accept", W'(div_by_zero), '0);
    wait_result("9/3", 32'd3, 32'd0, 1'b0, 33, -1);

    // Extremes.
    issue(32'h8000_0000, 32'hFFFF_FFFF);
    wait_result("min/-1", 32'h8000_0000, 32'd0, 1'b0, 33, -1);
    issue(32'h8000_0000, 32'd1);
    wait_result("min/1", 32'h8000_0000, 32'd0, 1'b0, 33, -1);
    issue(32'h7FFF_FFFF, 32'h8000_0000);
    wait_result("max/min", 32'd0, 32'h7FFF_FFFF, 1'b0, 33, -1);
    issue(32'd1000, 32'd1001);
    wait_result("1000/1001", 32'd0, 32'd1000, 1'b0, 33, -1);

    // Start during RUN is ignored; outputs hold afterwards.
    issue(32'd100, 32'd7);
    wait_result("100/7 with ignored start", 32'd14, 32'd2, 1'b0, 33, 9);
    repeat (5) @(negedge clock);
    chk("hold quotient", quotient, 32'd14);
    chk("hold remainder", remainder, 32'd2);
    chk("hold no valid", W'(result_valid), '0);

    // Asynchronous reset mid-RUN aborts the division.
    issue(32'd100, 32'd7);
    repeat (14) @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset quotient", quotient, '0);
    chk("async reset remainder", remainder, '0);
    chk("async reset busy", W'(busy), '0);
    chk("async reset valid", W'(result_valid), '0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (result_valid) cnt++;
    end
    chk("no valid after abort", W'(cnt), '0);
    issue(32'd81, 32'd9);
    wait_result("81/9", 32'd9, 32'd0, 1'b0, 33, -1);

    // Start held high: one result every WIDTH+2 cycles.
    @(negedge clock);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    cnt = 0;
    while (!result_valid && cnt < 60) begin
      @(negedge clock);
      cnt++;
    end
    chk("b2b first latency", W'(cnt), W'(34));
    gap = 0;
    do begin
      @(negedge clock);
      gap++;
    end while (!result_valid && gap < 60);
    start = 1'b0;
    chk("b2b period", W'(gap), W'(W + 2));
    chk("b2b quotient", quotient, 32'd14);
    repeat (40) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_seq_32.md
Name: div_seq_32

Overview:
- Multicycle signed integer divider for the multdiv unit; the inverse operation to the adder/multiplier datapath.
- Uses a shift-and-subtract (restoring) algorithm, one quotient bit per clock.
- Accepts operands on a start pulse and returns quotient, remainder and a divide-by-zero flag with a single-cycle valid pulse.

Parameters:
WIDTH, 32, operand/result width in bits (two's complement); iteration count equals WIDTH

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request; accepted when busy=0, operands sampled on the same edge
dividend  input  WIDTH  signed dividend
divisor  input  WIDTH  signed divisor
quotient  output  WIDTH  signed quotient, registered
remainder  output  WIDTH  signed remainder, registered
result_valid  output  1  one-cycle pulse: quotient/remainder/div_by_zero are valid
div_by_zero  output  1  set with result_valid when divisor was 0; held until next accepted start
busy  output  1  high while a division is in progress

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; quotient, remainder, result_valid, div_by_zero, busy and the iteration counter all 0.
- Reset asserted mid-division aborts the operation; no result_valid is produced.
- States: IDLE, RUN, DONE.
- Start acceptance: start is accepted on edge k when state is IDLE or DONE (busy=0). When busy=1, start is ignored.
- Accept with divisor != 0:
  - Latch |dividend|, |divisor|, sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend).
  - Clear the partial remainder and counter; state -> RUN; busy -> 1; div_by_zero -> 0.
- RUN: edges k+1..k+WIDTH each perform one iteration:
  - Shift {partial remainder, working dividend} left by 1.
  - Trial subtract |divisor| at WIDTH+1 bits.
  - If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set it to 0.
  - Counter increments each iteration.
- Edge k+WIDTH+1 (counter==WIDTH):
  - Write quotient = sign_q ? -Q : Q and remainder = sign_r ? -R : R.
  - result_valid -> 1, busy -> 0, state -> DONE.
- DONE lasts one cycle:
  - Next edge: result_valid -> 0, state -> IDLE, unless a new start is accepted on that edge (then RUN).
- Latency: result_valid is high in the cycle after edge k+WIDTH+1 (WIDTH+2 edges from acceptance, including the accept edge).
- Accept with divisor == 0:
  - At edge k: state -> DONE, quotient=0, remainder=0, div_by_zero=1, result_valid=1, busy stays 0.
- Quotient/remainder registers change only at the DONE-entry edge. They hold values through IDLE and during the next RUN until overwritten.
- Arithmetic rules:
  - Truncation toward zero; remainder takes the dividend's sign.
  - |remainder| < |divisor|; dividend = quotient*divisor + remainder (mod 2^WIDTH).
- Overflow case (-2^(WIDTH-1) / -1):
  - |dividend| = 2^(WIDTH-1) must be handled as an unsigned magnitude.
  - Result: quotient = -2^(WIDTH-1) (wraps), remainder = 0, div_by_zero=0, no other flag.
- Operand inputs are don't-care except on the accepting edge; changes during RUN have no effect.
- Back-to-back: start held high continuously yields one result every WIDTH+2 cycles.

Test Plan:
- 100 / 7, start on edge k:
  - busy=1 after k.
  - result_valid high only in the cycle after edge k+33, with quotient=14, remainder=2, div_by_zero=0.
  - busy=0 from edge k+33.
- Sign combinations:
  - -100/7 -> quotient=-14, remainder=-2.
  - 100/-7 -> quotient=-14, remainder=2.
  - -100/-7 -> quotient=14, remainder=-2.
  - 0/5 -> quotient=0, remainder=0.
- 1234 / 0:
  - result_valid and div_by_zero =1 in the cycle after the accept edge; quotient=0, remainder=0; busy never asserts.
  - A following 9/3 then clears div_by_zero and gives quotient=3, remainder=0.
- Extremes:
  - 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
  - 0x80000000 / 1 -> quotient=0x80000000.
  - 0x7FFFFFFF / 0x80000000 -> quotient=0, remainder=0x7FFFFFFF.
- Start pulsed again at edge k+10 during RUN with different operands:
  - Ignored; the original 100/7 result appears at the original time.
  - Outputs hold 14/2 until the next accepted start completes.
- reset_n driven low asynchronously mid-RUN (edge k+15):
  - All outputs 0 immediately; no result_valid afterward.
  - After release, a fresh 81/9 returns quotient=9, remainder=0 at the standard latency.
